// File: rtl/haf_use_nand_nand2.sv
// Two-input NAND primitive; the only gate used by the half-adder network.
module haf_use_nand_nand2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/haf_use_nand.sv
// NAND-only half adder with a registered copy of sum/carry.
// The five-NAND structure is kept explicit so X propagation matches gate semantics.
module haf_use_nand (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry,
  output logic sum_q,
  output logic carry_q
);

  logic n1;
  logic n2;
  logic n3;

  haf_use_nand_nand2 u_n1    (.a(a),  .b(b),  .y(n1));
  haf_use_nand_nand2 u_n2    (.a(a),  .b(n1), .y(n2));
  haf_use_nand_nand2 u_n3    (.a(b),  .b(n1), .y(n3));
  haf_use_nand_nand2 u_sum   (.a(n2), .b(n3), .y(sum));
  haf_use_nand_nand2 u_carry (.a(n1), .b(n1), .y(carry));

  // Output registers: captured as-is (no X filtering), cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

endmodule

// File: tb/tb_haf_use_nand.sv
// Scoreboard bench for haf_use_nand: expected {sum,carry} pairs are queued when driven.
module tb_haf_use_nand;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic sum;
  logic carry;
  logic sum_q;
  logic carry_q;

  int checks;
  int errors;
  logic [1:0] exp_q[$];
  logic probe;

  haf_use_nand dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got sum/carry=%b required %b", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", tag, got);
    end else begin
      chk(tag, got, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] pat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a = 1'b0;
    b = 1'b0;
    #2;
    exp_q.push_back(2'b00);
    pop_chk("reset_regs", {sum_q, carry_q});

    @(negedge clk);
    rst = 1'b0;

    // Exhaustive known inputs: combinational then registered result.
    for (int i = 0; i < 4; i++) begin
      pat = i[1:0];
      @(negedge clk);
      a = pat[1];
      b = pat[0];
      exp_q.push_back({pat[1] ^ pat[0], pat[1] & pat[0]});
      #1;
      pop_chk("comb", {sum, carry});
      exp_q.push_back({pat[1] ^ pat[0], pat[1] & pat[0]});
      @(posedge clk);
      #1;
      pop_chk("reg", {sum_q, carry_q});
    end

    // X cases only meaningful on a four-state simulator.
    probe = 1'bx;
    if (probe === 1'bx) begin
      @(negedge clk);
      a = 1'bx; b = 1'bx;
      exp_q.push_back(2'bxx);
      #1 pop_chk("x_x", {sum, carry});
      a = 1'bx; b = 1'b0;
      exp_q.push_back(2'bx0);
      #1 pop_chk("x_0", {sum, carry});
      a = 1'b0; b = 1'bx;
      exp_q.push_back(2'bx0);
      #1 pop_chk("0_x", {sum, carry});
    end

    // Registered path latency.
    @(negedge clk);
    a = 1'b1; b = 1'b1;
    exp_q.push_back(2'b01);
    @(posedge clk);
    #1 pop_chk("reg_11", {sum_q, carry_q});
    @(negedge clk);
    a = 1'b1; b = 1'b0;
    exp_q.push_back(2'b01);
    #1 pop_chk("reg_hold", {sum_q, carry_q});
    exp_q.push_back(2'b10);
    @(posedge clk);
    #1 pop_chk("reg_10", {sum_q, carry_q});

    // Asynchronous reset between edges.
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(2'b00);
    #1 pop_chk("async_rst", {sum_q, carry_q});
    exp_q.push_back(2'b10);
    pop_chk("comb_in_rst", {sum, carry});
    a = 1'b1; b = 1'b1;
    exp_q.push_back(2'b01);
    #1 pop_chk("comb_in_rst_11", {sum, carry});
    exp_q.push_back(2'b00);
    @(posedge clk);
    #1 pop_chk("rst_held_edge", {sum_q, carry_q});

    // Reset release: first capture at the following edge.
    @(negedge clk);
    a = 1'b0; b = 1'b1;
    #1 rst = 1'b0;
    exp_q.push_back(2'b00);
    #1 pop_chk("release_wait", {sum_q, carry_q});
    exp_q.push_back(2'b10);
    @(posedge clk);
    #1 pop_chk("release_cap", {sum_q, carry_q});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
